// File: rtl/rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: resynchronises the baud-domain
// frame-complete level, captures one byte per rising edge, and flags dropped bytes.
module rx_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              r_s1, r_s2, r_s3;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic w_wr_pulse, w_empty, w_full, w_pop, w_push, w_drop;

    // Sync flops reset high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= rx_done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_wr_pulse = r_s2 & ~r_s3;
        w_empty    = (r_count == '0);
        w_full     = (r_count == (ADDR_W+1)'(DEPTH));
        w_pop      = rd_en & ~w_empty;
        w_push     = w_wr_pulse & (~w_full | w_pop);
        w_drop     = w_wr_pulse & w_full & ~w_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            // A fresh overflow beats a simultaneous clear.
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    // Storage is never reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_comb begin
        dout  = w_empty ? '0 : r_mem[r_rd_ptr];
        empty = w_empty;
        full  = w_full;
        count = r_count;
        ovf   = r_ovf;
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: queue-based reference model plus a negedge monitor
// comparing status and head-of-queue data every cycle, with directed and random stimulus.
module tb_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       rx_done;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;

    rx_fifo #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .rx_done (rx_done),
        .rd_en   (rd_en),
        .ovf_clr (ovf_clr),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: expected FIFO contents, scheduled captures and overflow flag.
    typedef struct {
        int         t;
        logic [7:0] d;
    } pend_t;

    logic [7:0] mq[$];
    pend_t      pq[$];
    int         cyc    = 0;
    bit         m_prev = 1'b1;
    bit         m_ovf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            pq.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            bit         due;
            bit         pop;
            bit         acc;
            logic [7:0] d;
            cyc++;
            due = 1'b0;
            d   = 8'h00;
            if (pq.size() > 0 && pq[0].t == cyc) begin
                due = 1'b1;
                d   = pq[0].d;
                void'(pq.pop_front());
            end
            pop = rd_en && (mq.size() > 0);
            acc = due && (mq.size() < 8 || pop);
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (due && !acc) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            // A sampled rising edge of rx_done lands in the FIFO two edges later.
            if (rx_done && !m_prev) pq.push_back('{cyc + 2, din});
            m_prev = rx_done;
        end
    end

    // Monitor: whenever the DUT presents a head byte it must match the scoreboard front.
    always @(negedge clk) begin
        check("count", int'(count), mq.size());
        check("empty", int'(empty), int'(mq.size() == 0));
        check("full",  int'(full),  int'(mq.size() == 8));
        check("ovf",   int'(ovf),   int'(m_ovf));
        if (!empty) begin
            if (mq.size() > 0) check(rd_en ? "pop_data" : "head_data", int'(dout), int'(mq[0]));
        end else begin
            check("dout_when_empty", int'(dout), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b);
        din     = b;
        rx_done = 1'b1;
        tick(4);
        rx_done = 1'b0;
        tick(4);
    endtask

    // Frame whose capture edge coincides with a pop.
    task automatic frame_pop(input logic [7:0] b);
        din     = b;
        rx_done = 1'b1;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
        rx_done = 1'b0;
        tick(4);
    endtask

    task automatic frame_rand(input logic [7:0] b);
        din     = b;
        rx_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_en   = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            if (i == 4) rx_done = 1'b0;
            tick(1);
        end
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        tick(n);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; rx_done = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        tick(3);
        check("reset_empty", int'(empty), 1);
        check("reset_count", int'(count), 0);
        check("reset_ovf",   int'(ovf),   0);
        rst = 1'b0;
        tick(2);

        // Single byte and capture latency
        din = 8'hA5; rx_done = 1'b1;
        tick(1);
        check("lat_edge_n",   int'(empty), 1);
        tick(1);
        check("lat_edge_n1",  int'(empty), 1);
        tick(1);
        check("lat_edge_n2",  int'(empty), 0);
        check("first_dout",   int'(dout),  8'hA5);
        check("first_count",  int'(count), 1);
        rx_done = 1'b0;
        tick(5);
        drain(1);
        check("after_pop_empty", int'(empty), 1);
        check("after_pop_count", int'(count), 0);

        // Fill past full, overflow, drain in order, clear
        for (int i = 1; i <= 9; i++) frame(8'(i));
        check("fill_full",  int'(full),  1);
        check("fill_ovf",   int'(ovf),   1);
        check("fill_count", int'(count), 8);
        drain(8);
        check("drained_empty", int'(empty), 1);
        check("ovf_held",      int'(ovf),   1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);

        // Simultaneous write and pop while full
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i));
        frame_pop(8'h55);
        check("simul_count", int'(count), 8);
        check("simul_ovf",   int'(ovf),   0);
        drain(7);
        check("last_is_55", int'(dout), 8'h55);
        drain(1);

        // Pop requests while empty are ignored
        drain(5);
        check("empty_pop_count", int'(count), 0);
        check("empty_pop_empty", int'(empty), 1);
        frame(8'h3C);
        check("after_empty_pop_dout", int'(dout), 8'h3C);
        drain(1);

        // rx_done high across reset release, then one clean edge
        rx_done = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        check("no_spurious_write", int'(count), 0);
        rx_done = 1'b0;
        tick(3);
        frame(8'h77);
        check("one_write", int'(count), 1);
        for (int i = 0; i < 3; i++) frame(8'hC0 + 8'(i));
        check("four_stored", int'(count), 4);
        rst = 1'b1;
        #1;
        check("async_rst_empty", int'(empty), 1);
        check("async_rst_count", int'(count), 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Random interleaving forcing pointer wrap
        for (int i = 0; i < 24; i++) frame_rand(8'($urandom_range(0, 255)));
        drain(10);
        check("final_empty", int'(empty), 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
